mem_port_arbiter: RTL and testbench

- Shares the single read port of the on-chip program/data memory between two requesters:
  - requester 0: processor instruction fetch;
  - requester 1: data/debug reader (e.g. `ldc` operand path or a debug peek port).
- Sits between the requesters and the memory's `addr`/`strobe`/`dataRead` port.
- Issues at most one strobe per cycle and routes the one-cycle-latency read data back to the owner of that access.
- Supports a bounded bus lock so a multi-byte instruction fetch can complete without interleaving.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory read port between instruction
// fetch (requester 0) and the data/debug reader (requester 1).
// Grant is combinational; read data comes back one cycle later and is
// tagged to the owner through registered per-requester valid bits.
// A requester may lock the port for up to LOCK_MAX consecutive cycles so a
// multi-byte fetch is not interleaved.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin contention
// handling; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rspValid0,
  output logic                  rspValid1,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memStrobe,
  input  logic [DATA_WIDTH-1:0] memDataRead
);

  localparam int            CW   = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  // registered state
  logic          last_owner;
  logic          lock_active;
  logic          lock_owner;
  logic [CW-1:0] lock_count;
  // one valid flop per requester: bit X set == pendValid with pendOwner X.
  // Keeping them as separate flops makes rspValidX a clean register output.
  logic [1:0]    pend_vld;

  logic [1:0] req, lock, gnt;
  logic       owner_lock, other_req, at_max;
  logic       hold, force_rel, release_lock, pick, gsel;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};

  assign owner_lock = lock[lock_owner];
  assign other_req  = req[!lock_owner];
  assign at_max     = (lock_count == LMAX);

  // Lock still binding: owner keeps asserting lock and has budget left.
  // A dropped lock input frees the port in the same cycle.
  assign hold         = lock_active && owner_lock && !at_max;
  // Budget spent while the other side waits: hand the port over now.
  assign force_rel    = lock_active && owner_lock && at_max && other_req;
  assign release_lock = lock_active && (!owner_lock || (at_max && other_req));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // contention goes to whoever did not have the last access
  assign pick = !last_owner;
`else
  // fixed priority: requester 0 wins contention; last_owner is tracked
  // but does not steer the decision in this build
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
  assign pick = 1'b0;
`endif

  // grant decision: at most one grant per cycle
  always_comb begin
    gnt = '0;
    if (hold)
      gnt[lock_owner] = req[lock_owner];
    else if (force_rel)
      gnt[!lock_owner] = 1'b1;
    else if (&req)
      gnt[pick] = 1'b1;
    else
      gnt = req;
  end

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign gsel      = gnt[1];
  assign memStrobe = |gnt;

  // address mux, driven to zero when the port is idle
  always_comb begin
    memAddr = '0;
    if (gnt[1])
      memAddr = addr1;
    else if (gnt[0])
      memAddr = addr0;
  end

  // ownership, lock bookkeeping and response tagging
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_owner  <= 1'b1;
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      lock_count  <= '0;
      pend_vld    <= '0;
    end else begin
      pend_vld <= gnt;
      if (|gnt)
        last_owner <= gsel;
      if ((|gnt) && lock[gsel]) begin
        lock_active <= 1'b1;
        lock_owner  <= gsel;
        // continuing lock counts up; anything else starts a fresh lock
        if (lock_active && (lock_owner == gsel) && !release_lock)
          lock_count <= at_max ? LMAX : lock_count + 1'b1;
        else
          lock_count <= CW'(1);
      end else if (release_lock) begin
        lock_active <= 1'b0;
        lock_count  <= '0;
      end else if (lock_active) begin
        // owner holds the lock while idle; those cycles use up its budget
        lock_count <= at_max ? LMAX : lock_count + 1'b1;
      end
    end
  end

  assign rspValid0 = pend_vld[0];
  assign rspValid1 = pend_vld[1];
  assign rspData   = memDataRead;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a tiny one-cycle memory model, a
// response scoreboard queue (one entry per cycle) and immediate-assertion checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       req0, req1, lock0, lock1;
  logic [7:0] addr0, addr1;
  logic       gnt0, gnt1, rspValid0, rspValid1, memStrobe;
  logic [7:0] rspData, memAddr, memDataRead;

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LOCK_MAX(4)) dut (
    .clk(clk), .resetN(resetN),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rspValid0(rspValid0), .rspValid1(rspValid1), .rspData(rspData),
    .memAddr(memAddr), .memStrobe(memStrobe), .memDataRead(memDataRead)
  );

  always #5 clk = ~clk;

  // memory: data valid the cycle after strobe
  logic [7:0] mem [256];
  always @(posedge clk) if (memStrobe) memDataRead <= mem[memAddr];

  // own: 0 = no response, 1 = requester 0, 2 = requester 1
  typedef struct packed { logic [1:0] own; logic [7:0] data; } exp_t;
  exp_t sbq[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check grant side, retire previous response, push new
  task automatic step(input logic r0, input logic [7:0] a0, input logic l0,
                      input logic r1, input logic [7:0] a1, input logic l1,
                      input logic e0, input logic e1);
    exp_t prev, cur;
    logic [7:0] ea;
    @(posedge clk); #1;
    req0 = r0; addr0 = a0; lock0 = l0;
    req1 = r1; addr1 = a1; lock1 = l1;
    @(negedge clk);
    ea = e1 ? a1 : (e0 ? a0 : 8'h00);
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    chk("memStrobe", memStrobe, e0 | e1);
    chk("memAddr", memAddr, ea);
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      prev = sbq.pop_front();
      chk("rspValid0", rspValid0, prev.own == 2'd1);
      chk("rspValid1", rspValid1, prev.own == 2'd2);
      if (prev.own != 2'd0) chk("rspData", rspData, prev.data);
    end
    cur.own  = e0 ? 2'd1 : (e1 ? 2'd2 : 2'd0);
    cur.data = mem[ea];
    sbq.push_back(cur);
  endtask

  initial begin
    exp_t none;
    none = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[5] = 8'h1C;
    resetN = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; addr0 = 0; addr1 = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rspValid0", rspValid0, 0);
    chk("rst_rspValid1", rspValid1, 0);
    chk("rst_strobe", memStrobe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    sbq.push_back(none);
    #1 resetN = 1'b1;

    // single uncontended fetch at 0x05 -> 0x1C next cycle
    step(1, 8'h05, 0, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

    // lone requester 1 access
    step(0, 8'h00, 0, 1, 8'h10, 0, 0, 1);

    // continuous dual requests, no locks
`ifdef MEM_ARB_ROUND_ROBIN_EN
    step(1, 8'h00, 0, 1, 8'h10, 0, 1, 0);
    step(1, 8'h00, 0, 1, 8'h10, 0, 0, 1);
    step(1, 8'h00, 0, 1, 8'h10, 0, 1, 0);
    step(1, 8'h00, 0, 1, 8'h10, 0, 0, 1);
`else
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 1, 8'h10, 0, 1, 0);
`endif

    // locked 3-byte fetch with requester 1 waiting, then handover
    step(1, 8'h12, 1, 1, 8'h20, 0, 1, 0);
    step(1, 8'h13, 1, 1, 8'h20, 0, 1, 0);
    step(1, 8'h14, 1, 1, 8'h20, 0, 1, 0);
    step(0, 8'h00, 0, 1, 8'h20, 0, 0, 1);

    // lock held while owner idle blocks requester 1; dropping it frees the port
    step(1, 8'h30, 1, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 1, 8'h40, 0, 0, 0);
    step(0, 8'h00, 0, 1, 8'h40, 0, 0, 1);

    // lock never dropped: 4 owned cycles, forced release, gnt1 in cycle 5
    for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 1, 1, 8'h60, 0, 1, 0);
    step(1, 8'h54, 1, 1, 8'h60, 0, 0, 1);
    step(1, 8'h54, 1, 0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

    // reset pulsed the cycle after a locked grant
    step(1, 8'h70, 1, 0, 8'h00, 0, 1, 0);
    @(posedge clk); #1;
    resetN = 1'b0; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    @(negedge clk);
    chk("mid_rst_rspValid0", rspValid0, 0);
    chk("mid_rst_rspValid1", rspValid1, 0);
    chk("mid_rst_strobe", memStrobe, 0);
    sbq.delete();
    sbq.push_back(none);
    #1 resetN = 1'b1;
    // stale lock would block this; no response from the dropped access
    step(0, 8'h00, 1, 1, 8'h71, 0, 0, 1);
    step(1, 8'h72, 0, 1, 8'h73, 0, 1, 0);

    // idle: no strobe, zero address, responses die out
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);

    chk("sb_drained", sbq.size(), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
